// File: rtl/commit_map_release.sv
// commit_map_release
//
// Committed (architectural) rename map table with physical-register release
// and a sequential map-table copy-out used to rebuild the speculative map
// after a pipeline flush.
//
// Parameters
//   SIZE_RMT_LOG      log2 of the architectural register count
//   SIZE_PHYSICAL_LOG physical register tag width
//
// Ports
//   clk                      rising-edge clock
//   reset                    asynchronous active-low reset
//   commitValidK_i (K=0..3)  retiring instruction in slot K (slot 0 oldest)
//   commitWrK_i              slot K writes an architectural destination
//   commitArchK_i            destination architectural register of slot K
//   commitPhysK_i            physical register newly committed for slot K
//   recoverFlag_i            flush: start (or restart) the copy-out walk
//   freeValidK_o/freeRegK_o  registered release of the displaced mapping
//   recoverValid_o           copy-out beat valid
//   recoverIdx_o             beat index, covers arch registers 4*idx..4*idx+3
//   recoverPhysK_o           mapping of arch register 4*idx+K
//   busy_o                   copy-out in progress
module commit_map_release #(
    parameter int SIZE_RMT_LOG      = 5,
    parameter int SIZE_PHYSICAL_LOG = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         commitValid0_i,
    input  logic                         commitValid1_i,
    input  logic                         commitValid2_i,
    input  logic                         commitValid3_i,
    input  logic                         commitWr0_i,
    input  logic                         commitWr1_i,
    input  logic                         commitWr2_i,
    input  logic                         commitWr3_i,
    input  logic [SIZE_RMT_LOG-1:0]      commitArch0_i,
    input  logic [SIZE_RMT_LOG-1:0]      commitArch1_i,
    input  logic [SIZE_RMT_LOG-1:0]      commitArch2_i,
    input  logic [SIZE_RMT_LOG-1:0]      commitArch3_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhys0_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhys1_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhys2_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhys3_i,
    input  logic                         recoverFlag_i,
    output logic                         freeValid0_o,
    output logic                         freeValid1_o,
    output logic                         freeValid2_o,
    output logic                         freeValid3_o,
    output logic [SIZE_PHYSICAL_LOG-1:0] freeReg0_o,
    output logic [SIZE_PHYSICAL_LOG-1:0] freeReg1_o,
    output logic [SIZE_PHYSICAL_LOG-1:0] freeReg2_o,
    output logic [SIZE_PHYSICAL_LOG-1:0] freeReg3_o,
    output logic                         recoverValid_o,
    output logic [SIZE_RMT_LOG-3:0]      recoverIdx_o,
    output logic [SIZE_PHYSICAL_LOG-1:0] recoverPhys0_o,
    output logic [SIZE_PHYSICAL_LOG-1:0] recoverPhys1_o,
    output logic [SIZE_PHYSICAL_LOG-1:0] recoverPhys2_o,
    output logic [SIZE_PHYSICAL_LOG-1:0] recoverPhys3_o,
    output logic                         busy_o
);

    localparam int ARCH_N = 1 << SIZE_RMT_LOG;
    localparam int IDX_W  = SIZE_RMT_LOG - 2;

    typedef logic [SIZE_PHYSICAL_LOG-1:0] phys_t;
    typedef logic [SIZE_RMT_LOG-1:0]      arch_t;
    typedef logic [IDX_W-1:0]             idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } state_t;

    localparam idx_t LAST_IDX = {IDX_W{1'b1}};

    state_t state, next_state;
    idx_t   idx, next_idx;

    phys_t  map_table [ARCH_N];

    logic   slot_wr   [4];
    arch_t  slot_arch [4];
    phys_t  slot_phys [4];
    phys_t  prev_phys [4];

    logic   free_vld_p0 [4];
    phys_t  free_reg_p0 [4];

    // Commit request decode; commits only land while the walk is idle.
    always_comb begin
        slot_arch[0] = commitArch0_i;
        slot_arch[1] = commitArch1_i;
        slot_arch[2] = commitArch2_i;
        slot_arch[3] = commitArch3_i;
        slot_phys[0] = commitPhys0_i;
        slot_phys[1] = commitPhys1_i;
        slot_phys[2] = commitPhys2_i;
        slot_phys[3] = commitPhys3_i;
        slot_wr[0]   = commitValid0_i && commitWr0_i && (state == IDLE);
        slot_wr[1]   = commitValid1_i && commitWr1_i && (state == IDLE);
        slot_wr[2]   = commitValid2_i && commitWr2_i && (state == IDLE);
        slot_wr[3]   = commitValid3_i && commitWr3_i && (state == IDLE);
    end

    // Displaced mapping per slot: start from the table and let each older
    // same-group writer to the same arch register override it; scanning
    // oldest to youngest leaves the youngest earlier writer in place.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            prev_phys[k] = map_table[slot_arch[k]];
            for (int j = 0; j < 4; j++) begin
                if (j < k && slot_wr[j] && slot_arch[j] == slot_arch[k]) begin
                    prev_phys[k] = slot_phys[j];
                end
            end
        end
    end

    // Map table update; later slots overwrite earlier ones in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ARCH_N; i++) begin
                map_table[i] <= phys_t'(i);
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (slot_wr[k]) begin
                    map_table[slot_arch[k]] <= slot_phys[k];
                end
            end
        end
    end

    // Stage p0: registered release, one cycle after commit, slot-aligned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                free_vld_p0[k] <= 1'b0;
                free_reg_p0[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                free_vld_p0[k] <= slot_wr[k];
                free_reg_p0[k] <= slot_wr[k] ? prev_phys[k] : phys_t'(0);
            end
        end
    end

    // Copy-out walk FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
        end
    end

    always_comb begin
        next_state = state;
        next_idx   = idx;
        case (state)
            IDLE: begin
                next_idx = '0;
                if (recoverFlag_i) begin
                    next_state = WALK;
                end
            end
            WALK: begin
                if (recoverFlag_i) begin
                    next_idx = '0;
                end else if (idx == LAST_IDX) begin
                    next_state = IDLE;
                    next_idx   = '0;
                end else begin
                    next_idx = idx + 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
                next_idx   = '0;
            end
        endcase
    end

    // Beat data is read live from the table and forced to zero outside a walk.
    always_comb begin
        recoverValid_o = (state == WALK);
        busy_o         = (state == WALK);
        recoverIdx_o   = idx;
        recoverPhys0_o = '0;
        recoverPhys1_o = '0;
        recoverPhys2_o = '0;
        recoverPhys3_o = '0;
        if (state == WALK) begin
            recoverPhys0_o = map_table[{idx, 2'd0}];
            recoverPhys1_o = map_table[{idx, 2'd1}];
            recoverPhys2_o = map_table[{idx, 2'd2}];
            recoverPhys3_o = map_table[{idx, 2'd3}];
        end
    end

    assign freeValid0_o = free_vld_p0[0];
    assign freeValid1_o = free_vld_p0[1];
    assign freeValid2_o = free_vld_p0[2];
    assign freeValid3_o = free_vld_p0[3];
    assign freeReg0_o   = free_reg_p0[0];
    assign freeReg1_o   = free_reg_p0[1];
    assign freeReg2_o   = free_reg_p0[2];
    assign freeReg3_o   = free_reg_p0[3];

endmodule

// File: doc/commit_map_release.md
COMMIT_MAP_RELEASE -- requirements
Module: commit_map_release

Interface
REQ-001 SHALL have parameter SIZE_RMT_LOG, default 5, log2 of architectural register count (32 entries).
REQ-002 SHALL have parameter SIZE_PHYSICAL_LOG, default 7, physical register tag width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports commitValidK_i  input  1  (K=0..3) retiring instruction in slot K, slot 0 oldest.
REQ-006 SHALL have ports commitWrK_i  input  1  slot K writes an architectural destination.
REQ-007 SHALL have ports commitArchK_i  input  SIZE_RMT_LOG  destination architectural register of slot K.
REQ-008 SHALL have ports commitPhysK_i  input  SIZE_PHYSICAL_LOG  physical register newly committed for slot K.
REQ-009 SHALL have port recoverFlag_i  input  1  pipeline flush; start map-table copy-out.
REQ-010 SHALL have ports freeValidK_o  output  1  physical register in freeRegK_o is released to the free list.
REQ-011 SHALL have ports freeRegK_o  output  SIZE_PHYSICAL_LOG  released physical register tag, slot K.
REQ-012 SHALL have port recoverValid_o  output  1  copy-out beat valid.
REQ-013 SHALL have port recoverIdx_o  output  SIZE_RMT_LOG-2  beat index; beat covers architectural registers 4*idx..4*idx+3.
REQ-014 SHALL have ports recoverPhysK_o  output  SIZE_PHYSICAL_LOG  mapping of architectural register 4*idx+K.
REQ-015 SHALL have port busy_o  output  1  copy-out in progress; rename must stall.

Function
REQ-016 SHALL hold a committed map table, one SIZE_PHYSICAL_LOG entry per architectural register.
REQ-017 SHALL treat slot K as writing only when commitValidK_i and commitWrK_i are both high.
REQ-018 SHALL process writing slots in order 0 to 3 within one cycle.
REQ-019 SHALL release, for writing slot K, the previous mapping of commitArchK_i: the commitPhys of the youngest earlier writing slot in the same group with equal arch, else the table entry.
REQ-020 SHALL write the table entry for each arch register with the commitPhys of the youngest writing slot targeting it; older same-group writers do not update the table.
REQ-021 SHALL register freeValidK_o/freeRegK_o: visible exactly one cycle after the commit cycle, slot position preserved (no compaction).
REQ-022 SHALL drive freeValidK_o low and freeRegK_o to 0 for non-writing slots.
REQ-023 SHALL implement FSM states IDLE and WALK; IDLE to WALK on recoverFlag_i high.
REQ-024 SHALL, in WALK, emit one beat per cycle with recoverIdx_o from 0 to 2^SIZE_RMT_LOG/4-1 (0..7 by default), recoverValid_o high; WALK to IDLE after the last beat.
REQ-025 SHALL hold busy_o high from the cycle after recoverFlag_i through the last beat.
REQ-026 SHALL apply commits presented in the same cycle as recoverFlag_i before the walk; the first beat reflects them.
REQ-027 SHALL ignore commits while in WALK: no table update, freeValid low.
REQ-028 SHALL restart the walk at index 0 when recoverFlag_i is asserted during WALK.
REQ-029 SHALL read recoverPhysK_o combinationally from the table at the current index, so each beat shows table state at that cycle.

Reset
REQ-030 SHALL, on reset low, immediately set table entry i to physical tag i, FSM to IDLE, and walk index to 0.
REQ-031 SHALL, on reset low, immediately drive all freeValidK_o, recoverValid_o, busy_o to 0 and all freeRegK_o, recoverPhysK_o, recoverIdx_o to 0.
REQ-032 SHALL abort an in-progress walk on reset, with no further beats.
REQ-033 SHALL ignore commits and recoverFlag_i while reset is low and accept them from the first rising edge after release.

Verification
REQ-034 SHALL pass: after reset, slot0 writes arch 3 phys 40 -> next cycle freeValid0_o=1, freeReg0_o=3; table[3]=40.
REQ-035 SHALL pass: slots 0,2 both write arch 5 (phys 50, 51), table[5]=5 -> freeReg0_o=5, freeReg2_o=50, table[5]=51.
REQ-036 SHALL pass: slot1 valid with commitWr1_i=0, slot3 writes arch 31 phys 90 -> freeValid1_o=0, freeValid3_o=1, freeReg3_o=31.
REQ-037 SHALL pass: recoverFlag_i together with slot0 writing arch 0 phys 70 -> beats idx 0..7 over 8 cycles, beat 0 recoverPhys0_o=70, busy_o high 8 cycles.
REQ-038 SHALL pass: recoverFlag_i re-asserted at beat 4 -> next beat idx=0, 8 further beats.
REQ-039 SHALL pass: reset low at beat 3 -> recoverValid_o and busy_o 0 immediately, table[i]=i.
